div32_restoring: RTL and testbench



---
 rtl/div32_restoring.sv | 117 +++++++++++
 tb/tb_div32_restoring.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div32_restoring.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, quotient and remainder held until the next result.
module div32_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Handshake: start is sampled only in IDLE; busy is high in RUN and DONE;
  // done is a one-cycle pulse during which quotient/remainder/div_by_zero
  // carry the new result, and they stay put until the following done.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic             last;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // The stored partial remainder is always below the divisor, so its top bit
  // is zero and only the shifted (WIDTH+1)-bit form needs the extra bit.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    trial   = r_shift + ~{1'b0, dvsr} + {{WIDTH{1'b0}}, 1'b1};
    if (!trial[WIDTH]) begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = r_shift[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end
    last = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor != '0) ? RUN : DONE;
      RUN:  if (last)  state_nxt = DONE;
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvsr        <= '0;
      r           <= '0;
      q           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dvsr  <= divisor;
              r     <= '0;
              q     <= dividend;
              count <= '0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r     <= r_nxt;
          q     <= q_nxt;
          count <= count + CW'(1);
          if (last) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_restoring.sv
// Randomized bench for div32_restoring: expected results from plain / and %
// go into a queue at each accepted start; a monitor pops them on every done.
module tb_div32_restoring;

  localparam int W  = 32;
  localparam int EW = 32 + 1 + 2 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  div32_restoring #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            tests  = 0;
  int            fails  = 0;
  logic          orphan = 1'b0;
  logic          prev_done = 1'b0;
  logic [W-1:0]  hq = '0, hr = '0;
  logic          hd = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {due cycle, div_by_zero, quotient, remainder}
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [31:0] due);
    if (b == 0) return {due, 1'b1, {W{1'b1}}, a};
    return {due, 1'b0, a / b, a % b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (busy && guard < W + 4) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL issue_wait: busy stuck high, got 1 expected 0");
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    exp_q.push_back(model(a, b, cyc + ((b == 0) ? 0 : W)));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 4 * W) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0 || busy) begin
      tests++; fails++;
      $display("FAIL wait_idle: pending %0d results, busy %0b, expected none", exp_q.size(), busy);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    check("busy_model", {31'b0, busy}, {31'b0, (exp_q.size() != 0) || orphan});
    if (done) begin
      if (prev_done) begin
        tests++; fails++;
        $display("FAIL done_pulse: done high two cycles in a row, expected single pulse");
      end
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done with no result pending, expected none");
      end else begin
        e = exp_q.pop_front();
        check("quotient",    quotient,  e[2*W-1:W]);
        check("remainder",   remainder, e[W-1:0]);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e[2*W]});
        check("latency",     cyc, e[EW-1:2*W+1]);
        hq = e[2*W-1:W];
        hr = e[W-1:0];
        hd = e[2*W];
      end
    end else begin
      check("hold_quotient",  quotient,  hq);
      check("hold_remainder", remainder, hr);
      check("hold_dbz",       {31'b0, div_by_zero}, {31'b0, hd});
    end
    prev_done = done;
    if (rst) begin
      hq = '0; hr = '0; hd = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b;
    int sel;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);

    issue(32'd100, 32'd7);
    issue(32'hFFFF_FFFF, 32'd1);
    issue(32'hFFFF_FFFF, 32'h0001_0000);
    issue(32'd5, 32'd0);
    issue(32'd9, 32'd3);
    issue(32'd3, 32'd10);
    // Start pulse at RUN iteration 10 must be ignored.
    repeat (9) begin @(posedge clk); #1; end
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    issue(32'd50, 32'd5);
    issue(32'd0, 32'd9);
    issue(32'd12345, 32'd12345);
    wait_idle();

    // Reset mid-RUN discards the divide and clears the outputs.
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; orphan = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; orphan = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", remainder, '0);
    check("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    issue(32'd1000, 32'd3);

    for (int i = 0; i < 1000; i++) begin
      a   = $urandom >> $urandom_range(0, 31);
      b   = $urandom >> $urandom_range(0, 31);
      sel = $urandom_range(0, 31);
      if (sel == 1) b = a;
      if (sel == 2) a = '0;
      if (b == 0 && sel != 0) b = 32'd1;
      if (sel == 0) b = '0;
      issue(a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) begin
          if (busy) begin @(posedge clk); #1; end
        end
        if (busy) begin
          dividend = $urandom; divisor = $urandom; start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    wait_idle();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
